pe_array_tile_sequencer: RTL

Control FSM that sequences one layer on the PE array, tile by tile. Per layer it optionally loads the 32-bit bias in four byte beats. Per output tile it issues clear, runs the MAC accumulation window and drains the PE pipeline. When OUTPUT_PRECISION packs 2 or 4 sub-tiles into one output word, it captures the sub-tile results into the output buffer chain before presenting the packed result to the writeback stage.

---
 rtl/pe_array_tile_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pe_array_tile_sequencer.sv
// Layer sequencer for the PE array: optional bias load, then per packed tile
// clear -> (accumulate, drain, capture) x sub-tiles -> output handshake.
module pe_array_tile_sequencer #(
   parameter int CNT_WIDTH = 16,
   parameter int PIPE_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] cfg_acc_len,
   input  logic [CNT_WIDTH-1:0] cfg_n_tiles,
   input  logic [1:0]           cfg_output_precision,
   input  logic                 cfg_bias_en,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 enable,
   output logic                 clear,
   output logic                 first_mac,
   output logic                 enable_bias_32bits,
   output logic [1:0]           addr_bias_32bits,
   output logic                 enable_BUFFERED_OUTPUT,
   output logic                 out_valid,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE, S_BIAS, S_CLEAR, S_ACC, S_DRAIN, S_CAPTURE, S_OUT, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]           sub_q, sub_d;
   logic [CNT_WIDTH-1:0] tile_q, tile_d;
   logic [CNT_WIDTH-1:0] acc_last_q, acc_last_d;
   logic [CNT_WIDTH-1:0] n_tiles_q, n_tiles_d;
   logic [1:0]           g_last_q, g_last_d;

   logic       busy_q, busy_d, enable_q, enable_d, clear_q, clear_d;
   logic       first_mac_q, first_mac_d, bias_en_q, bias_en_d;
   logic [1:0] addr_q, addr_d;
   logic       capture_q, capture_d, out_valid_q, out_valid_d, done_q, done_d;

   always_comb begin
      // NOTE: every signal gets a default here so no path through the case infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      sub_d      = sub_q;
      tile_d     = tile_q;
      acc_last_d = acc_last_q;
      n_tiles_d  = n_tiles_q;
      g_last_d   = g_last_q;

      case (state_q)
         S_IDLE: if (start) begin
            acc_last_d = (cfg_acc_len == '0) ? '0 : cfg_acc_len - 1'b1;
            n_tiles_d  = cfg_n_tiles;
            g_last_d   = (cfg_output_precision == 2'd1) ? 2'd1 :
                         (cfg_output_precision == 2'd2) ? 2'd3 : 2'd0;
            cnt_d      = '0;
            sub_d      = '0;
            tile_d     = '0;
            if (cfg_n_tiles == '0)  state_d = S_DONE;
            else if (cfg_bias_en)   state_d = S_BIAS;
            else                    state_d = S_CLEAR;
         end
         S_BIAS: begin
            if (cnt_q == CNT_WIDTH'(3)) begin
               cnt_d   = '0;
               state_d = S_CLEAR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            sub_d   = '0;
            state_d = S_ACC;
         end
         S_ACC: begin
            if (cnt_q == acc_last_q) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_WIDTH'(PIPE_LAT - 1)) begin
               cnt_d   = '0;
               state_d = (sub_q == g_last_q) ? S_OUT : S_CAPTURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            sub_d   = sub_q + 1'b1;
            state_d = S_ACC;
         end
         S_OUT: if (out_ready) begin
            tile_d  = tile_q + 1'b1;
            state_d = (tile_d == n_tiles_q) ? S_DONE : S_CLEAR;
         end
         S_DONE: begin
            tile_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         sub_d   = '0;
         tile_d  = '0;
      end

      // Outputs are decoded from the next state so the flops line up with it.
      busy_d      = (state_d != S_IDLE);
      enable_d    = (state_d == S_ACC) || (state_d == S_DRAIN);
      clear_d     = (state_d == S_CLEAR);
      first_mac_d = (state_d == S_ACC) && (cnt_d == '0);
      bias_en_d   = (state_d == S_BIAS);
      addr_d      = (state_d == S_BIAS) ? cnt_d[1:0] : 2'd0;
      capture_d   = (state_d == S_CAPTURE);
      out_valid_d = (state_d == S_OUT);
      done_d      = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sub_q       <= '0;
         tile_q      <= '0;
         acc_last_q  <= '0;
         n_tiles_q   <= '0;
         g_last_q    <= '0;
         busy_q      <= 1'b0;
         enable_q    <= 1'b0;
         clear_q     <= 1'b0;
         first_mac_q <= 1'b0;
         bias_en_q   <= 1'b0;
         addr_q      <= 2'd0;
         capture_q   <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sub_q       <= sub_d;
         tile_q      <= tile_d;
         acc_last_q  <= acc_last_d;
         n_tiles_q   <= n_tiles_d;
         g_last_q    <= g_last_d;
         busy_q      <= busy_d;
         enable_q    <= enable_d;
         clear_q     <= clear_d;
         first_mac_q <= first_mac_d;
         bias_en_q   <= bias_en_d;
         addr_q      <= addr_d;
         capture_q   <= capture_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign busy               = busy_q;
   assign enable             = enable_q;
   assign clear              = clear_q;
   assign first_mac          = first_mac_q;
   assign enable_bias_32bits = bias_en_q;
   assign addr_bias_32bits   = addr_q;
   assign out_valid          = out_valid_q;
   assign done               = done_q;
   // The buffer chain shifts on capture and on the exact cycle the packed word is accepted.
   assign enable_BUFFERED_OUTPUT = capture_q | (out_valid_q & out_ready);

endmodule
